// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) doubling, state/column types and the MixColumns FSM states.
package aes_pkg;
    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int         AES_NB   = 4;

    typedef logic [0:127] state_t;
    typedef logic [0:31]  col_t;

    typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_DONE} mc_state_e;

    // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/mix_col_unit.sv
// Combinational single-column MixColumns; the inverse matrix is only built with INV_MIX_COLUMNS_EN.
module mix_col_unit
    import aes_pkg::*;
(
    input  col_t i_col,
    input  logic i_inv,
    output col_t o_col
);
    logic [7:0] w_a  [4];
    logic [7:0] w_x2 [4];

    for (genvar i = 0; i < 4; i++) begin : g_in
        assign w_a[i]  = i_col[8*i +: 8];
        assign w_x2[i] = xtime(w_a[i]);
    end

`ifdef INV_MIX_COLUMNS_EN
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];

    for (genvar i = 0; i < 4; i++) begin : g_chain
        assign w_x4[i] = xtime(w_x2[i]);
        assign w_x8[i] = xtime(w_x4[i]);
    end
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
`endif

    // Circulant rows: byte i uses a[i], a[i+1], a[i+2], a[i+3] (mod 4).
    for (genvar i = 0; i < 4; i++) begin : g_out
        localparam int J1 = (i + 1) % 4;
        localparam int J2 = (i + 2) % 4;
        localparam int J3 = (i + 3) % 4;
        logic [7:0] w_fwd;
        assign w_fwd = w_x2[i] ^ w_x2[J1] ^ w_a[J1] ^ w_a[J2] ^ w_a[J3];
`ifdef INV_MIX_COLUMNS_EN
        logic [7:0] w_inv;
        // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
        assign w_inv = (w_x8[i]  ^ w_x4[i]  ^ w_x2[i])
                     ^ (w_x8[J1] ^ w_x2[J1] ^ w_a[J1])
                     ^ (w_x8[J2] ^ w_x4[J2] ^ w_a[J2])
                     ^ (w_x8[J3] ^ w_a[J3]);
        assign o_col[8*i +: 8] = i_inv ? w_inv : w_fwd;
`else
        assign o_col[8*i +: 8] = w_fwd;
`endif
    end
endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Optional InvMixColumns selected by defining INV_MIX_COLUMNS_EN.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e  r_state;
    logic [1:0] r_col_cnt;
    state_t     r_data;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       w_inv;
    logic       w_last;

    logic [1:0] w_idx     [COLS_PER_CYCLE];
    col_t       w_col_in  [COLS_PER_CYCLE];
    col_t       w_col_out [COLS_PER_CYCLE];

`ifdef INV_MIX_COLUMNS_EN
    logic r_inv;
    assign w_inv = r_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_inv        = 1'b0;
`endif

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign w_idx[g]    = r_col_cnt + 2'(g);
        assign w_col_in[g] = r_data[32*w_idx[g] +: 32];
        mix_col_unit u_unit (
            .i_col (w_col_in[g]),
            .i_inv (w_inv),
            .o_col (w_col_out[g])
        );
    end

    assign w_last    = ({1'b0, r_col_cnt} + 3'(COLS_PER_CYCLE)) == 3'(AES_NB);
    // rst gating keeps in_ready low during the reset cycle itself.
    assign in_ready  = r_in_ready & ~rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MC_IDLE;
            r_col_cnt   <= 2'd0;
            r_data      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef INV_MIX_COLUMNS_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            case (r_state)
                MC_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_data     <= in_data;
`ifdef INV_MIX_COLUMNS_EN
                        r_inv      <= in_inv;
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        r_data[32*w_idx[g] +: 32] <= w_col_out[g];
                    end
                    r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
                    if (w_last) begin
                        r_state     <= MC_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                MC_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= MC_IDLE;
                    end
                end
                default: r_state <= MC_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2, 4 columns/cycle) share the inputs.
module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_inv, out_ready;
    logic [127:0] in_data;
    logic         ir1, ir2, ir4, ov1, ov2, ov4;
    logic [127:0] od1, od2, od4;
    int           n_run = 0;
    int           n_fail = 0;

    localparam logic [127:0] ST_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] EXP_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] ST_B  = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] EXP_B = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
    localparam logic [127:0] ST_C  = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
    localparam logic [127:0] EXP_C = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov1), .out_ready(out_ready), .out_data(od1));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov2), .out_ready(out_ready), .out_data(od2));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov4), .out_ready(out_ready), .out_data(od4));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a state on dut1's handshake; returns just after the accept edge.
    task automatic send(input logic [127:0] d, input logic inv);
        int k;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        k = 0;
        while (!ir1 && k < 20) begin
            step();
            k++;
        end
        chk("send in_ready", 128'(ir1), 128'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [127:0] d, output int lat);
        lat = -1;
        d   = '0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ov1) begin
                d   = od1;
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        logic [127:0] d;
        int           lat, l1, l2, l4;
        logic [127:0] d1, d2, d4;
        logic [127:0] res [3];
        int           nres;

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1; in_data = '0;
        step();
        step();
        chk("rst in_ready", 128'(ir1), 128'd0);
        chk("rst out_valid", 128'(ov1), 128'd0);
        chk("rst out_data", od1, 128'd0);
        rst = 1'b0;
        step();
        chk("post-rst in_ready", 128'(ir1), 128'd1);

        // Latency and forward result for all three widths, accepted on the same edge.
        send(ST_A, 1'b0);
        l1 = -1; l2 = -1; l4 = -1; d1 = '0; d2 = '0; d4 = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (ov1 && l1 < 0) begin l1 = k; d1 = od1; end
            if (ov2 && l2 < 0) begin l2 = k; d2 = od2; end
            if (ov4 && l4 < 0) begin l4 = k; d4 = od4; end
        end
        chk("lat C1", 128'(l1), 128'd4);
        chk("lat C2", 128'(l2), 128'd2);
        chk("lat C4", 128'(l4), 128'd1);
        chk("fwd C1", d1, EXP_A);
        chk("fwd C2", d2, EXP_A);
        chk("fwd C4", d4, EXP_A);
        chk("idle after handoff", 128'(ir1), 128'd1);
        chk("ov low after handoff", 128'(ov1), 128'd0);

        // Backpressure: DONE held, competing in_valid ignored.
        out_ready = 1'b0;
        send(ST_B, 1'b0);
        wait_out(d, lat);
        chk("bp lat", 128'(lat), 128'd4);
        chk("bp data", d, EXP_B);
        in_valid = 1'b1;
        in_data  = ST_A;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp out_valid", 128'(ov1), 128'd1);
            chk("bp out_data", od1, EXP_B);
            chk("bp in_ready", 128'(ir1), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp release", 128'(ov1), 128'd0);
        step();
        step();

        // Reset on the second BUSY cycle.
        send(ST_A, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst out_valid", 128'(ov1), 128'd0);
        chk("midrst out_data", od1, 128'd0);
        chk("midrst in_ready", 128'(ir1), 128'd1);
        send(ST_B, 1'b0);
        wait_out(d, lat);
        chk("fresh lat", 128'(lat), 128'd4);
        chk("fresh data", d, EXP_B);
        step();

        // Back-to-back with in_valid held high.
        nres = 0;
        fork
            begin
                logic [127:0] st [3];
                st[0] = ST_A; st[1] = ST_B; st[2] = ST_C;
                in_valid = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    logic acc;
                    int   g;
                    in_data = st[i];
                    acc = 1'b0;
                    g = 0;
                    while (!acc && g < 30) begin
                        acc = ir1;
                        step();
                        g++;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 80 && nres < 3; k++) begin
                    step();
                    if (ov1) begin
                        res[nres] = od1;
                        nres++;
                    end
                end
            end
        join
        for (int k = 0; k < 12; k++) begin
            step();
            if (ov1) nres++;
        end
        chk("b2b count", 128'(nres), 128'd3);
        chk("b2b res0", res[0], EXP_A);
        chk("b2b res1", res[1], EXP_B);
        chk("b2b res2", res[2], EXP_C);

`ifdef INV_MIX_COLUMNS_EN
        send(EXP_C, 1'b1);
        wait_out(d, lat);
        chk("inv lat", 128'(lat), 128'd4);
        chk("inv data", d, ST_C);
        step();
        for (int n = 0; n < 100; n++) begin
            logic [127:0] s, f;
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(s, 1'b0);
            wait_out(f, lat);
            step();
            send(f, 1'b1);
            wait_out(d, lat);
            step();
            chk("inv identity", d, s);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
